// File: rtl/case_2_sdiv_13s_5s_8_seq.sv
// Multi-cycle signed restoring divider (13s / 5s -> 8s quotient, 5s remainder)
// under an ap_start/ap_done handshake with a shared ce stall.
module case_2_sdiv_13s_5s_8_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 13,
  parameter int din1_WIDTH = 5,
  parameter int dout_WIDTH = 8,
  parameter int NUM_STAGE  = 15
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ce,
  input  logic                  ap_start,
  output logic                  ap_ready,
  output logic                  ap_idle,
  output logic                  ap_done,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(din0_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(din0_WIDTH - 1);
  // ID is an instance tag and NUM_STAGE is fixed by din0_WIDTH; neither drives logic.
  localparam int unused_params = ID + NUM_STAGE;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]      cnt;
  logic [din0_WIDTH-1:0] dividend;
  logic [din1_WIDTH-1:0] divisor;
  logic [din1_WIDTH-1:0] part_rem;
  logic [dout_WIDTH-1:0] quo;
  logic [din1_WIDTH-1:0] din0_low;
  logic                  sign_a;
  logic                  sign_b;

  logic [din1_WIDTH:0]   shifted;
  logic                  fits;
  logic [din1_WIDTH-1:0] rem_next;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state <= IDLE;
    end else if (ce) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ap_ready   = 1'b0;
    ap_idle    = 1'b0;
    ap_done    = 1'b0;
    case (state)
      IDLE: begin
        ap_idle = 1'b1;
        if (ce && ap_start && !ap_rst) begin
          ap_ready   = 1'b1;
          state_next = CALC;
        end
      end
      CALC: if (cnt == LAST_CNT) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: begin
        ap_done    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Restoring step: the remainder stays below |din1| <= 2^(din1_WIDTH-1), so
  // the subtraction can be done modulo 2^din1_WIDTH once the trial says it fits.
  assign shifted  = {part_rem, dividend[din0_WIDTH-1]};
  assign fits     = shifted >= {1'b0, divisor};
  assign rem_next = fits ? (shifted[din1_WIDTH-1:0] - divisor) : shifted[din1_WIDTH-1:0];

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      cnt         <= '0;
      dividend    <= '0;
      divisor     <= '0;
      part_rem    <= '0;
      quo         <= '0;
      din0_low    <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      dout        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (ap_start) begin
            sign_a   <= din0[din0_WIDTH-1];
            sign_b   <= din1[din1_WIDTH-1];
            dividend <= din0[din0_WIDTH-1] ? -din0 : din0;
            divisor  <= din1[din1_WIDTH-1] ? -din1 : din1;
            din0_low <= din0[din1_WIDTH-1:0];
            cnt      <= '0;
            part_rem <= '0;
            quo      <= '0;
          end
        end
        CALC: begin
          dividend <= dividend << 1;
          part_rem <= rem_next;
          quo      <= {quo[dout_WIDTH-2:0], fits};
          cnt      <= cnt + CNT_W'(1);
        end
        FIX: begin
          // A zero divisor lets every trial succeed; its result is replaced here.
          if (divisor == '0) begin
            dout        <= '1;
            rem         <= din0_low;
            div_by_zero <= 1'b1;
          end else begin
            dout        <= (sign_a ^ sign_b) ? -quo : quo;
            rem         <= sign_a ? -part_rem : part_rem;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_case_2_sdiv_13s_5s_8_seq.sv
// Randomized and directed bench for the sequential signed divider, checked
// against C-style truncating division computed with plain integer arithmetic.
module tb_case_2_sdiv_13s_5s_8_seq;

  localparam int W0 = 13;
  localparam int W1 = 5;
  localparam int WQ = 8;
  // ap_done is seen after edge W0+1 counted from the accept edge (edge 0).
  localparam int LAT_EDGES = W0 + 1;
  localparam int PERIOD    = W0 + 3;

  logic                 ap_clk = 1'b0;
  logic                 ap_rst;
  logic                 ce;
  logic                 ap_start;
  logic                 ap_ready;
  logic                 ap_idle;
  logic                 ap_done;
  logic signed [W0-1:0] din0;
  logic signed [W1-1:0] din1;
  logic [WQ-1:0]        dout;
  logic [W1-1:0]        rem;
  logic                 div_by_zero;

  int total = 0;
  int bad   = 0;

  case_2_sdiv_13s_5s_8_seq dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .ap_start(ap_start),
    .ap_ready(ap_ready), .ap_idle(ap_idle), .ap_done(ap_done),
    .din0(din0), .din1(din1), .dout(dout), .rem(rem), .div_by_zero(div_by_zero)
  );

  always #5 ap_clk = ~ap_clk;

  function automatic void model(input logic signed [W0-1:0] a, input logic signed [W1-1:0] b,
                                output logic [WQ-1:0] q, output logic [W1-1:0] r, output logic z);
    int ai, bi, qi, ri;
    ai = a;
    bi = b;
    if (bi == 0) begin
      q = '1;
      r = a[W1-1:0];
      z = 1'b1;
    end else begin
      qi = ai / bi;
      ri = ai % bi;
      q  = qi[WQ-1:0];
      r  = ri[W1-1:0];
      z  = 1'b0;
    end
  endfunction

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  // Runs one operation from IDLE with ce high; returns edges to ap_done and
  // whether ap_done dropped back to IDLE one edge later.
  task automatic do_op(input logic signed [W0-1:0] a, input logic signed [W1-1:0] b,
                       output int lat, output logic rdy, output logic pulse_ok,
                       output logic [WQ-1:0] q, output logic [W1-1:0] r, output logic z);
    din0 = a;
    din1 = b;
    ap_start = 1'b1;
    #1 rdy = ap_ready;
    step();
    ap_start = 1'b0;
    lat = 0;
    while (!ap_done && lat < 40) begin
      step();
      lat++;
    end
    q = dout;
    r = rem;
    z = div_by_zero;
    step();
    pulse_ok = !ap_done && ap_idle;
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    ap_start = 1'b1;
    step();
    step();
    #1;
    total++;
    if (ap_idle !== 1'b1 || ap_ready !== 1'b0 || ap_done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_ctrl idle=%b ready=%b done=%b want 1 0 0", ap_idle, ap_ready, ap_done);
    end
    total++;
    if (dout !== '0 || rem !== '0 || div_by_zero !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_data dout=%h rem=%h dbz=%b want 0 0 0", dout, rem, div_by_zero);
    end
    ap_start = 1'b0;
    ap_rst = 1'b0;
    step();
  endtask

  typedef struct {
    logic signed [W0-1:0] a;
    logic signed [W1-1:0] b;
    logic [WQ-1:0]        q;
    logic [W1-1:0]        r;
    logic                 z;
  } vec_t;

  task automatic test_directed();
    vec_t vecs[$];
    int lat;
    logic rdy, pok, z;
    logic [WQ-1:0] q;
    logic [W1-1:0] r;
    vecs.push_back('{13'sd1000,  5'sd3,   8'h4D, 5'h01, 1'b0});
    vecs.push_back('{-13'sd100,  5'sd7,   8'hF2, 5'h1E, 1'b0});
    vecs.push_back('{13'sd100,  -5'sd7,   8'hF2, 5'h02, 1'b0});
    vecs.push_back('{-13'sd100, -5'sd7,   8'h0E, 5'h1E, 1'b0});
    vecs.push_back('{-13'sd4096, -5'sd1,  8'h00, 5'h00, 1'b0});
    vecs.push_back('{13'sd4095, -5'sd16,  8'h01, 5'h0F, 1'b0});
    vecs.push_back('{13'sd0,     5'sd5,   8'h00, 5'h00, 1'b0});
    vecs.push_back('{13'sd50,    5'sd0,   8'hFF, 5'h12, 1'b1});
    vecs.push_back('{13'sd50,    5'sd5,   8'h0A, 5'h00, 1'b0});
    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, lat, rdy, pok, q, r, z);
      total++;
      if (rdy !== 1'b1 || lat != LAT_EDGES || pok !== 1'b1) begin
        bad++;
        $display("[TB] FAIL dir_timing[%0d] ready=%b lat=%0d pulse_ok=%b want 1 %0d 1", i, rdy, lat, pok, LAT_EDGES);
      end
      total++;
      if (q !== vecs[i].q || r !== vecs[i].r || z !== vecs[i].z) begin
        bad++;
        $display("[TB] FAIL dir_result %0d/%0d got q=%h r=%h z=%b want q=%h r=%h z=%b",
                 vecs[i].a, vecs[i].b, q, r, z, vecs[i].q, vecs[i].r, vecs[i].z);
      end
    end
  endtask

  task automatic test_random();
    int lat;
    logic rdy, pok, z, ez;
    logic [WQ-1:0] q, eq;
    logic [W1-1:0] r, er;
    logic signed [W0-1:0] a;
    logic signed [W1-1:0] b;
    for (int n = 0; n < 40; n++) begin
      a = W0'($urandom);
      b = W1'($urandom);
      model(a, b, eq, er, ez);
      do_op(a, b, lat, rdy, pok, q, r, z);
      total++;
      if (q !== eq || r !== er || z !== ez || lat != LAT_EDGES) begin
        bad++;
        $display("[TB] FAIL rand %0d/%0d got q=%h r=%h z=%b lat=%0d want q=%h r=%h z=%b lat=%0d",
                 a, b, q, r, z, lat, eq, er, ez, LAT_EDGES);
      end
    end
  endtask

  task automatic test_ce_stall();
    int lat;
    logic [WQ-1:0] eq;
    logic [W1-1:0] er;
    logic ez;
    model(-13'sd1234, 5'sd9, eq, er, ez);
    din0 = -13'sd1234;
    din1 = 5'sd9;
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    lat = 0;
    repeat (5) begin step(); lat++; end
    ce = 1'b0;
    repeat (4) begin
      step();
      lat++;
      total++;
      if (ap_done !== 1'b0 || ap_idle !== 1'b0) begin
        bad++;
        $display("[TB] FAIL stall_hold done=%b idle=%b want 0 0", ap_done, ap_idle);
      end
    end
    ce = 1'b1;
    while (!ap_done && lat < 60) begin step(); lat++; end
    total++;
    if (lat != LAT_EDGES + 4 || dout !== eq || rem !== er || div_by_zero !== ez) begin
      bad++;
      $display("[TB] FAIL stall_result lat=%0d q=%h r=%h z=%b want lat=%0d q=%h r=%h z=%b",
               lat, dout, rem, div_by_zero, LAT_EDGES + 4, eq, er, ez);
    end
    ce = 1'b0;
    repeat (2) begin
      step();
      total++;
      if (ap_done !== 1'b1) begin
        bad++;
        $display("[TB] FAIL done_held done=%b want 1", ap_done);
      end
    end
    ce = 1'b1;
    step();
    total++;
    if (ap_done !== 1'b0 || ap_idle !== 1'b1) begin
      bad++;
      $display("[TB] FAIL done_release done=%b idle=%b want 0 1", ap_done, ap_idle);
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    logic [WQ-1:0] eq;
    logic [W1-1:0] er;
    logic ez;
    model(13'sd777, -5'sd6, eq, er, ez);
    din0 = 13'sd777;
    din1 = -5'sd6;
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    lat = 0;
    repeat (3) begin step(); lat++; end
    din0 = 13'sd5;
    din1 = 5'sd1;
    ap_start = 1'b1;
    #1;
    total++;
    if (ap_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL start_in_calc ready=%b want 0", ap_ready);
    end
    step();
    lat++;
    ap_start = 1'b0;
    while (!ap_done && lat < 40) begin step(); lat++; end
    total++;
    if (lat != LAT_EDGES || dout !== eq || rem !== er || div_by_zero !== ez) begin
      bad++;
      $display("[TB] FAIL start_ignored lat=%0d q=%h r=%h z=%b want lat=%0d q=%h r=%h z=%b",
               lat, dout, rem, div_by_zero, LAT_EDGES, eq, er, ez);
    end
    step();
  endtask

  task automatic test_reset_abort();
    int lat;
    logic rdy, pok, z, ez;
    logic [WQ-1:0] q, eq;
    logic [W1-1:0] r, er;
    din0 = -13'sd100;
    din1 = 5'sd7;
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    repeat (5) step();
    ap_rst = 1'b1;
    step();
    total++;
    if (ap_idle !== 1'b1 || ap_done !== 1'b0 || dout !== '0 || rem !== '0 || div_by_zero !== 1'b0) begin
      bad++;
      $display("[TB] FAIL abort_state idle=%b done=%b q=%h r=%h z=%b want 1 0 0 0 0",
               ap_idle, ap_done, dout, rem, div_by_zero);
    end
    ap_rst = 1'b0;
    model(13'sd50, 5'sd5, eq, er, ez);
    do_op(13'sd50, 5'sd5, lat, rdy, pok, q, r, z);
    total++;
    if (rdy !== 1'b1 || lat != LAT_EDGES || q !== eq || r !== er || z !== ez) begin
      bad++;
      $display("[TB] FAIL after_abort ready=%b lat=%0d q=%h r=%h z=%b want 1 %0d %h %h %b",
               rdy, lat, q, r, z, LAT_EDGES, eq, er, ez);
    end
  endtask

  task automatic test_back_to_back();
    int gap;
    logic [WQ-1:0] eq;
    logic [W1-1:0] er;
    logic ez;
    model(-13'sd3000, 5'sd11, eq, er, ez);
    din0 = -13'sd3000;
    din1 = 5'sd11;
    ap_start = 1'b1;
    #1;
    step();
    gap = 1;
    while (!ap_ready && gap < 60) begin
      if (ap_done) begin
        total++;
        if (dout !== eq || rem !== er || div_by_zero !== ez) begin
          bad++;
          $display("[TB] FAIL b2b_result q=%h r=%h z=%b want %h %h %b", dout, rem, div_by_zero, eq, er, ez);
        end
      end
      step();
      gap++;
    end
    total++;
    if (gap != PERIOD) begin
      bad++;
      $display("[TB] FAIL b2b_period got=%0d want=%0d", gap, PERIOD);
    end
    step();
    ap_start = 1'b0;
    repeat (PERIOD) step();
  endtask

  initial begin
    ap_rst = 1'b1;
    ce = 1'b1;
    ap_start = 1'b0;
    din0 = '0;
    din1 = '0;
    step();
    test_reset();
    test_directed();
    test_random();
    test_ce_stall();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/case_2_sdiv_13s_5s_8_seq.md
Name: case_2_sdiv_13s_5s_8_seq

Overview:
- Multi-cycle signed integer divider; the inverse companion of the kernel's 8s x 5s -> 13s multiplier.
- Recovers a narrow quotient and remainder from a wide product-width dividend.
- Sits inside the generated kernel datapath under the scheduler's ap_start/ap_done handshake and the shared ce stall.
- Iterative restoring algorithm, one quotient bit per cycle, fixed latency so the scheduler can place it statically.

Parameters:
- ID, 1, instance identifier (unused in logic)
- din0_WIDTH, 13, signed dividend width
- din1_WIDTH, 5, signed divisor width
- dout_WIDTH, 8, signed quotient output width (truncated)
- NUM_STAGE, 15, fixed accept-to-done latency; must equal din0_WIDTH+2

Ports:
- ap_clk  in  1  clock, rising edge
- ap_rst  in  1  synchronous active-high reset
- ce  in  1  clock enable; 0 freezes all state
- ap_start  in  1  request; operands valid while high
- ap_ready  out  1  one-cycle pulse when operands are captured
- ap_idle  out  1  high in IDLE
- ap_done  out  1  one-cycle pulse when results are valid
- din0  in  din0_WIDTH  signed dividend
- din1  in  din1_WIDTH  signed divisor
- dout  out  dout_WIDTH  signed quotient, low dout_WIDTH bits
- rem  out  din1_WIDTH  signed remainder
- div_by_zero  out  1  set with results when din1 was 0

Behaviour:
- Reset (synchronous, ap_rst=1 at a rising edge):
  - state=IDLE; ap_ready=0, ap_done=0, ap_idle=1.
  - dout=0, rem=0, div_by_zero=0; counter and datapath registers cleared.
  - Reset overrides ce and aborts any operation in flight; no ap_done is issued for it.
- ce=0: state, counter, datapath and all outputs hold. ap_ready/ap_done do not pulse, and a held ap_done stays high until a ce=1 edge.
- Semantics: C-style truncation toward zero, remainder takes the dividend's sign; din0 = q*din1 + r with |r| < |din1|.
  - dout = q mod 2^dout_WIDTH, wrapping with no saturation.
  - rem always fits din1_WIDTH because |r| <= 2^(din1_WIDTH-1)-1.
- States:
  - IDLE: ap_idle=1. On ce & ap_start:
    - capture sign(din0), sign(din1), |din0| (din0_WIDTH-bit unsigned, so -4096 maps to 4096) and |din1| (din1_WIDTH-bit unsigned).
    - pulse ap_ready, clear counter, go to CALC.
  - CALC: din0_WIDTH cycles (counter 0..din0_WIDTH-1).
    - Each cycle: shift the next dividend MSB into the din1_WIDTH+1-bit partial remainder, trial-subtract |din1|, keep on non-negative, shift the result bit into the quotient register.
    - After the last count go to FIX.
  - FIX: negate the quotient if the signs differ and negate the remainder if the dividend is negative. Register dout, rem and div_by_zero, then go to DONE.
  - DONE: ap_done=1 for one cycle, then go to IDLE. ap_start is not sampled in DONE.
- Latency: capture at edge 0, ap_done high in the cycle after edge din0_WIDTH+1 (15 cycles, ce held 1). Throughput is one operation per din0_WIDTH+3 cycles.
- ap_start while not IDLE is ignored; it is accepted on the first IDLE cycle where it is still high.
- Outputs hold their last values until the next FIX.
- Divide by zero: latency is unchanged. Result is dout = all ones, rem = din0[din1_WIDTH-1:0], div_by_zero=1. The datapath iterates but FIX overrides the result.

Test Plan:
- 1000 / 3 -> ap_ready at accept, ap_done exactly 15 cycles later; dout=0x4D (333 wrapped), rem=0x01, div_by_zero=0.
- Signs: -100/7 -> dout=0xF2, rem=0x1E (-2); 100/-7 -> dout=0xF2, rem=0x02; -100/-7 -> dout=0x0E, rem=0x1E.
- Extremes: -4096/-1 -> dout=0x00, rem=0x00; 4095/-16 -> dout=0x01 (-255 wrapped), rem=0x0F; 0/5 -> dout=0x00, rem=0x00.
- 50/0 -> ap_done still at 15 cycles; dout=0xFF, rem=0x12, div_by_zero=1. A following 50/5 clears the flag, dout=0x0A.
- ce held low for 4 cycles mid-CALC -> ap_done delayed exactly 4 cycles and results unchanged. ap_start pulsed during CALC -> ignored, no ap_ready.
- ap_rst asserted mid-CALC -> next edge: IDLE, ap_idle=1, dout/rem=0, no ap_done. A new ap_start the cycle after reset is accepted normally.
